ram_emu_read_arbiter: RTL and testbench

Shares the single PIO RAM emulator read link (2-bit tx/rx pin pair, read latency 22 cycles start-bit to start-bit) between NUM_REQ internal read clients.
- Sits between the clients and the tx message serializer / rx reply deserializer.
- Picks one client per command round-robin and issues its address downstream.
- Records the issuing client ID in an in-order FIFO, then routes each returned reply word to the client at the FIFO head.

---
 rtl/ram_emu_read_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_emu_read_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram_emu_read_arbiter.sv
// Round-robin read arbiter for the shared RAM emulator link; in-order ID FIFO routes replies back to clients.
// Optional reply watchdog enabled by defining RAM_EMU_ARB_TIMEOUT_EN (default build: rsp_err tied 0, waits forever).
module ram_emu_read_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_BITS       = 16,
    parameter int DATA_BITS       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]           req_addr,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic                                   cmd_valid,
    input  logic                                   cmd_ready,
    output logic [ADDR_BITS-1:0]                   cmd_addr,
    input  logic                                   rsp_in_valid,
    input  logic [DATA_BITS-1:0]                   rsp_in_data,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [DATA_BITS-1:0]                   rsp_data,
    output logic                                   rsp_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_sticky
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [IDW-1:0] ID_ONE  = IDW'(1);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] head_id;
    logic           any_req;
    logic           issue;
    logic           reply_ok;
    logic           timeout_fire;
    logic           pop;
    logic [NUM_REQ-1:0] head_onehot;
    logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           rsp_err_q;

    // Scan downward from the farthest slot so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    assign cmd_valid = any_req && (outstanding < CNT_MAX);
    assign cmd_addr  = req_addr[winner*ADDR_BITS +: ADDR_BITS];
    assign issue     = cmd_valid && cmd_ready;
    assign reply_ok  = rsp_in_valid && (outstanding != '0);
    assign pop       = reply_ok || timeout_fire;
    assign head_id   = id_mem[rd_ptr];

    always_comb begin
        req_ready = '0;
        if (issue) req_ready[winner] = 1'b1;
        head_onehot = '0;
        head_onehot[head_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (issue) id_mem[wr_ptr] <= winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err_sticky  <= 1'b0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                rr_ptr <= (winner == LAST_ID) ? '0 : winner + ID_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (issue && !pop)      outstanding <= outstanding + CNT_ONE;
            else if (pop && !issue) outstanding <= outstanding - CNT_ONE;
            if (rsp_in_valid && (outstanding == '0)) err_sticky <= 1'b1;
            rsp_valid <= pop ? head_onehot : '0;
            rsp_err_q <= timeout_fire;
            if (reply_ok)          rsp_data <= rsp_in_data;
            else if (timeout_fire) rsp_data <= '0;
        end
    end

`ifdef RAM_EMU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] WD_ONE  = TW'(1);
    logic [TW-1:0] wd_cnt;

    // A real reply in the expiry cycle takes precedence over the watchdog.
    assign timeout_fire = (outstanding != '0) && (wd_cnt == WD_LAST) && !rsp_in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (reply_ok || timeout_fire || (issue && (outstanding == '0))) begin
            wd_cnt <= '0;
        end else if (outstanding != '0) begin
            wd_cnt <= wd_cnt + WD_ONE;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_fire = 1'b0;
    assign rsp_err      = 1'b0;
    logic unused_err;
    assign unused_err = rsp_err_q;
`endif
endmodule

// File: tb/tb_ram_emu_read_arbiter.sv
// Directed bench for ram_emu_read_arbiter: NUM_REQ=2, MAX_OUTSTANDING=4, 16-bit address/data.
module tb_ram_emu_read_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [31:0] req_addr;
    logic [1:0]  req_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic        rsp_in_valid;
    logic [15:0] rsp_in_data;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  outstanding;
    logic        err_sticky;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_emu_read_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .outstanding(outstanding), .err_sticky(err_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_grant [4];
        logic [1:0] exp_route [4];
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_route = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n = 1'b0; req_valid = '0; req_addr = {16'h5678, 16'h1234};
        cmd_ready = 1'b0; rsp_in_valid = 1'b0; rsp_in_data = '0;
        #3;
        chk("reset_outstanding", 32'(outstanding), 0);
        chk("reset_rsp_valid",   32'(rsp_valid), 0);
        chk("reset_rsp_data",    32'(rsp_data), 0);
        chk("reset_rsp_err",     32'(rsp_err), 0);
        chk("reset_err_sticky",  32'(err_sticky), 0);
        chk("reset_cmd_valid",   32'(cmd_valid), 0);
        #9 rst_n = 1'b1;
        tick();

        // single client read
        req_valid = 2'b01; cmd_ready = 1'b1;
        #1;
        chk("single_cmd_valid", 32'(cmd_valid), 1);
        chk("single_cmd_addr",  32'(cmd_addr), 32'h1234);
        chk("single_req_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        chk("single_out_1", 32'(outstanding), 1);
        for (int i = 0; i < 21; i++) tick();
        rsp_in_valid = 1'b1; rsp_in_data = 16'hBEEF;
        #1;
        chk("single_rsp_not_yet", 32'(rsp_valid), 0);
        tick();
        rsp_in_valid = 1'b0;
        chk("single_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("single_rsp_data",  32'(rsp_data), 32'hBEEF);
        chk("single_rsp_err",   32'(rsp_err), 0);
        chk("single_out_0",     32'(outstanding), 0);
        tick();
        chk("single_rsp_pulse", 32'(rsp_valid), 0);
        chk("single_data_hold", 32'(rsp_data), 32'hBEEF);

        // fresh reset so the first fair grant starts at client 0
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        req_valid = 2'b11; cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fair_grant_%0d", i), 32'(req_ready), 32'(exp_grant[i]));
            chk($sformatf("fair_addr_%0d", i), 32'(cmd_addr), exp_grant[i][0] ? 32'h1234 : 32'h5678);
            tick();
        end
        chk("full_out_4",     32'(outstanding), 4);
        chk("full_cmd_valid", 32'(cmd_valid), 0);
        chk("full_req_ready", 32'(req_ready), 0);
        tick();
        chk("full_stays_4", 32'(outstanding), 4);

        // four in-order replies; slot frees on the cycle after the first
        cmd_ready = 1'b0; rsp_in_valid = 1'b1; rsp_in_data = 16'hA000;
        #1;
        chk("full_cmd_valid_reply_cycle", 32'(cmd_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("route_%0d", i), 32'(rsp_valid), 32'(exp_route[i]));
            chk($sformatf("route_data_%0d", i), 32'(rsp_data), 32'hA000 + 32'(i));
            chk($sformatf("route_out_%0d", i), 32'(outstanding), 32'(3 - i));
            if (i == 0) chk("cmd_valid_reassert", 32'(cmd_valid), 1);
            rsp_in_data = 16'hA000 + 16'(i + 1);
            if (i == 3) rsp_in_valid = 1'b0;
        end

        // simultaneous issue and reply at outstanding=2
        cmd_ready = 1'b1; req_valid = 2'b11;
        tick(); tick();
        chk("simul_pre_out", 32'(outstanding), 2);
        req_valid = 2'b10; rsp_in_valid = 1'b1; rsp_in_data = 16'hC000;
        #1;
        chk("simul_grant", 32'(req_ready), 32'b10);
        tick();
        chk("simul_out_2",     32'(outstanding), 2);
        chk("simul_rsp_oldest", 32'(rsp_valid), 32'b01);
        chk("simul_rsp_data",  32'(rsp_data), 32'hC000);
        req_valid = '0; cmd_ready = 1'b0; rsp_in_data = 16'hC001;
        tick();
        chk("simul_rsp_2", 32'(rsp_valid), 32'b10);
        rsp_in_data = 16'hC002;
        tick();
        rsp_in_valid = 1'b0;
        chk("simul_rsp_3",  32'(rsp_valid), 32'b10);
        chk("simul_out_0",  32'(outstanding), 0);
        chk("simul_sticky", 32'(err_sticky), 0);

        // reply with nothing outstanding
        rsp_in_valid = 1'b1; rsp_in_data = 16'hDDDD;
        tick();
        rsp_in_valid = 1'b0;
        chk("empty_rsp_valid", 32'(rsp_valid), 0);
        chk("empty_sticky",    32'(err_sticky), 1);
        chk("empty_data_hold", 32'(rsp_data), 32'hC002);
        tick();
        chk("empty_sticky_holds", 32'(err_sticky), 1);

        // reset mid-burst with 3 outstanding
        req_valid = 2'b01; cmd_ready = 1'b1;
        tick(); tick(); tick();
        req_valid = '0; cmd_ready = 1'b0;
        chk("burst_out_3", 32'(outstanding), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out",       32'(outstanding), 0);
        chk("async_sticky",    32'(err_sticky), 0);
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rsp_data",  32'(rsp_data), 0);
        chk("async_cmd_valid", 32'(cmd_valid), 0);
        #2 rst_n = 1'b1;
        tick();
        rsp_in_valid = 1'b1; rsp_in_data = 16'h5A5A;
        tick();
        rsp_in_valid = 1'b0;
        chk("stale_rsp_valid", 32'(rsp_valid), 0);
        chk("stale_sticky",    32'(err_sticky), 1);

`ifdef RAM_EMU_ARB_TIMEOUT_EN
        req_valid = 2'b10; cmd_ready = 1'b1;
        tick();
        req_valid = '0; cmd_ready = 1'b0;
        chk("to_out_1", 32'(outstanding), 1);
        for (int i = 0; i < 63; i++) tick();
        chk("to_not_early", 32'(rsp_valid), 0);
        tick();
        chk("to_rsp_valid", 32'(rsp_valid), 32'b10);
        chk("to_rsp_err",   32'(rsp_err), 1);
        chk("to_rsp_data",  32'(rsp_data), 0);
        chk("to_out_0",     32'(outstanding), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
